// File: rtl/axi_write_ctrl_if.sv
// rtl/axi_write_ctrl_if.sv - AXI3 write-channel (AW/W/B) signal bundle
interface axi_write_ctrl_if #(
    parameter int ID_W = 4
) ();
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_write_ctrl.sv
// rtl/axi_write_ctrl.sv - SRAM-like store port to single-beat AXI3 write engine
module axi_write_ctrl #(
    parameter int            ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = ID_W'(1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic              bus_err,
    output logic              wr_pending,
    output logic [31:0]       wr_pending_addr,
    axi_write_ctrl_if.master  axi
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  size_q, size_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        pending_q, pending_d;
    logic        data_ok_q, data_ok_d;
    logic        bus_err_q, bus_err_d;
    logic        aw_hs, w_hs;
    logic        unused_bid;

    assign aw_hs      = awvalid_q & axi.awready;
    assign w_hs       = wvalid_q & axi.wready;
    assign unused_bid = ^axi.bid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            size_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            pending_q <= 1'b0;
            data_ok_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            size_q    <= size_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            pending_q <= pending_d;
            data_ok_q <= data_ok_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        size_d    = size_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        pending_d = pending_q;
        data_ok_d = 1'b0;
        bus_err_d = 1'b0;
        addr_ok   = 1'b0;

        case (state_q)
            IDLE: begin
                addr_ok = req;
                if (req) begin
                    addr_d    = addr;
                    wdata_d   = wdata;
                    wstrb_d   = wstrb;
                    size_d    = size;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    pending_d = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                // AW and W complete independently; leave once both have been seen.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = WAIT_B;
                end
            end
            WAIT_B: begin
                if (axi.bvalid & bready_q) begin
                    bready_d  = 1'b0;
                    pending_d = 1'b0;
                    data_ok_d = 1'b1;
                    bus_err_d = (axi.bresp != 2'b00);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_ok         = data_ok_q;
    assign bus_err         = bus_err_q;
    assign wr_pending      = pending_q;
    assign wr_pending_addr = addr_q;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = awvalid_q;
    assign axi.wid     = AXI_ID;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
endmodule

// File: tb/tb_axi_write_ctrl.sv
// tb/tb_axi_write_ctrl.sv - self-checking bench for axi_write_ctrl
module tb_axi_write_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok, data_ok, bus_err, wr_pending;
    logic [31:0] wr_pending_addr;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    axi_write_ctrl_if #(.ID_W(4)) axi ();

    axi_write_ctrl #(.ID_W(4), .AXI_ID(4'd1)) dut (
        .clk(clk), .reset(reset), .req(req), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .bus_err(bus_err), .wr_pending(wr_pending), .wr_pending_addr(wr_pending_addr),
        .axi(axi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the accept cycle. The slave raises awready/wready after da/dw
    // cycles of valid, and bvalid db cycles after bready rises.
    task automatic run_txn(input logic [31:0] a, input logic [1:0] sz, input logic [3:0] st,
                           input logic [31:0] d, input int da, input int dw, input int db,
                           input logic [1:0] br, input bit chained_in, input bit chain_out,
                           input bit hold_req, input logic [31:0] na, input logic [31:0] nd);
        int h, fin;
        h   = 1 + ((da > dw) ? da : dw);
        fin = h + 2 + db;
        for (int c = (chained_in ? 1 : 0); c <= fin; c++) begin
            if (c == 0) begin
                req = 1'b1; addr = a; size = sz; wstrb = st; wdata = d;
            end else if (c == fin && chain_out) begin
                req = 1'b1; addr = na; size = 2'd2; wstrb = 4'hF; wdata = nd;
            end else if (hold_req && c < fin) begin
                req = 1'b1; addr = a ^ 32'hFFFF_0000; wdata = ~d; wstrb = ~st;
            end else begin
                req = 1'b0; addr = $urandom; wdata = $urandom;
            end
            axi.awready = (c >= 1 + da);
            axi.wready  = (c >= 1 + dw);
            axi.bvalid  = (c == h + 1 + db);
            axi.bresp   = br;
            axi.bid     = 4'($urandom);
            #4;
            chk("addr_ok", addr_ok, (c == 0) || (c == fin && chain_out));
            chk("awvalid", axi.awvalid, (c >= 1 && c <= 1 + da));
            chk("wvalid", axi.wvalid, (c >= 1 && c <= 1 + dw));
            chk("bready", axi.bready, (c >= h + 1 && c <= h + 1 + db));
            chk("wr_pending", wr_pending, (c >= 1 && c <= h + 1 + db));
            chk("data_ok", data_ok, (c == fin));
            if (c == fin) chk("bus_err", bus_err, (br != 2'b00));
            if (c >= 1 && c <= h + 1 + db) begin
                chk("awaddr", axi.awaddr, a);
                chk("wdata", axi.wdata, d);
                chk("wstrb", axi.wstrb, st);
                chk("awsize", axi.awsize, {1'b0, sz});
                chk("wr_pending_addr", wr_pending_addr, a);
            end
            next_cycle();
        end
        if (!chain_out) req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; size = 2'd0; addr = '0; wstrb = '0; wdata = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.bresp = 2'b00; axi.bid = 4'd0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #4;
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_data_ok", data_ok, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_wr_pending", wr_pending, 0);
        chk("rst_awaddr", axi.awaddr, 0);
        chk("rst_wdata", axi.wdata, 0);
        chk("rst_addr_ok", addr_ok, 0);
        chk("awid", axi.awid, 4'd1);
        chk("wid", axi.wid, 4'd1);
        chk("awlen", axi.awlen, 0);
        chk("awburst", axi.awburst, 2'b01);
        chk("awlock", axi.awlock, 0);
        chk("awcache", axi.awcache, 0);
        chk("awprot", axi.awprot, 0);
        chk("wlast", axi.wlast, 1);
        next_cycle();

        // word write, all readies high
        run_txn(32'h1C00_0010, 2'd2, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        // AW stalled four cycles, W immediate
        run_txn(32'h1C00_0020, 2'd2, 4'hF, 32'h1234_5678, 4, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        // W stalled, B delayed
        run_txn(32'h1C00_0024, 2'd1, 4'h3, 32'h0000_A5A5, 0, 3, 2, 2'b00, 0, 0, 0, 0, 0);
        // byte store with SLVERR
        run_txn(32'h1C00_0013, 2'd0, 4'b1000, 32'hAB00_0000, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0);
        // back-to-back with req held across the data_ok cycle
        run_txn(32'h1C00_0100, 2'd2, 4'hF, 32'h1111_1111, 0, 0, 0, 2'b00, 0, 1, 0,
                32'h1C00_0200, 32'h2222_2222);
        run_txn(32'h1C00_0200, 2'd2, 4'hF, 32'h2222_2222, 1, 0, 0, 2'b11, 1, 0, 0, 0, 0);
        // busy back-pressure
        run_txn(32'h1C00_0300, 2'd2, 4'hF, 32'h3333_3333, 2, 1, 2, 2'b00, 0, 0, 1, 0, 0);

        // reset while waiting for B
        req = 1'b1; addr = 32'h1C00_0400; size = 2'd2; wstrb = 4'hF; wdata = 32'h4444_4444;
        axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0;
        #4; chk("rstb_accept", addr_ok, 1);
        next_cycle();
        req = 1'b0;
        next_cycle();
        reset = 1'b1;
        #4; chk("rstb_bready_before", axi.bready, 1);
        next_cycle();
        reset = 1'b0; axi.bvalid = 1'b1;
        #4;
        chk("rstb_awvalid", axi.awvalid, 0);
        chk("rstb_wvalid", axi.wvalid, 0);
        chk("rstb_bready", axi.bready, 0);
        chk("rstb_wr_pending", wr_pending, 0);
        chk("rstb_data_ok0", data_ok, 0);
        next_cycle();
        axi.bvalid = 1'b0;
        #4; chk("rstb_data_ok1", data_ok, 0);
        next_cycle();

        for (int i = 0; i < 20; i++) begin
            run_txn($urandom, 2'($urandom_range(0, 2)), 4'($urandom), $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                    2'($urandom), 0, 0, 1'($urandom), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
